// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and helpers that derive the per-axis
// totals and sync window bounds from porch/sync widths.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int MAX_TOTAL     = 1024;
  localparam int COUNT_W       = 10;

  function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int axis_sync_start(input int vis, input int fp);
    return vis + fp;
  endfunction

  // Exclusive upper bound of the sync window.
  function automatic int axis_sync_end(input int vis, input int fp, input int sync);
    return vis + fp + sync;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a wrapping position counter plus combinational decode of
// its next value, so the parent can register decode aligned with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   TOTAL       = 800,
  parameter int   VIS         = 640,
  parameter int   SYNC_START  = 656,
  parameter int   SYNC_END    = 752,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] next_count,
  output logic               wrap,
  output logic               active,
  output logic               sync
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TOTAL - 1);

  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W:0]   next_wide_s;

  assign count = count_r;

  // Next-position computation and decode of that next position.
  always_comb begin
    wrap        = en & (count_r == LAST);
    next_count  = count_r;
    if (wrap) begin
      next_count = {COUNT_W{1'b0}};
    end else if (en) begin
      next_count = count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      next_count = count_r;
    end
    // Widened compare so bounds equal to 1024 stay meaningful.
    next_wide_s = {1'b0, next_count};
    active      = (next_wide_s < (COUNT_W+1)'(VIS));
    if ((next_wide_s >= (COUNT_W+1)'(SYNC_START)) && (next_wide_s < (COUNT_W+1)'(SYNC_END))) begin
      sync = SYNC_ACTIVE;
    end else begin
      sync = ~SYNC_ACTIVE;
    end
  end

  // Position register; reset parks on the last position so the first
  // enabled cycle wraps to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= LAST;
    end else begin
      count_r <= next_count;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: chains horizontal and vertical axis counters and
// registers sync, visible-area flag, line/frame pulses and a frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = DEF_H_VISIBLE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_VISIBLE   = DEF_V_VISIBLE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic                vga_clk,
  input  logic                reset,
  output logic                hs,
  output logic                vs,
  output logic                blank,
  output logic [COUNT_W-1:0]  DrawX,
  output logic [COUNT_W-1:0]  DrawY,
  output logic                line_start,
  output logic                frame_start,
  output logic [7:0]          frame_cnt
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  logic [COUNT_W-1:0] h_next_s;
  logic [COUNT_W-1:0] v_next_s;
  logic               h_wrap_s;
  logic               v_wrap_s;
  logic               h_active_s;
  logic               v_active_s;
  logic               h_sync_s;
  logic               v_sync_s;
  logic               first_frame_r;

  vga_axis_counter #(
    .TOTAL       (H_TOTAL),
    .VIS         (H_VISIBLE),
    .SYNC_START  (axis_sync_start(H_VISIBLE, H_FP)),
    .SYNC_END    (axis_sync_end(H_VISIBLE, H_FP, H_SYNC)),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_h_axis (
    .clk        (vga_clk),
    .reset      (reset),
    .en         (1'b1),
    .count      (DrawX),
    .next_count (h_next_s),
    .wrap       (h_wrap_s),
    .active     (h_active_s),
    .sync       (h_sync_s)
  );

  vga_axis_counter #(
    .TOTAL       (V_TOTAL),
    .VIS         (V_VISIBLE),
    .SYNC_START  (axis_sync_start(V_VISIBLE, V_FP)),
    .SYNC_END    (axis_sync_end(V_VISIBLE, V_FP, V_SYNC)),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_v_axis (
    .clk        (vga_clk),
    .reset      (reset),
    .en         (h_wrap_s),
    .count      (DrawY),
    .next_count (v_next_s),
    .wrap       (v_wrap_s),
    .active     (v_active_s),
    .sync       (v_sync_s)
  );

  // Decode registered from next-state counts so it lines up with DrawX/DrawY.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs          <= ~SYNC_ACTIVE;
      vs          <= ~SYNC_ACTIVE;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= h_sync_s;
      vs          <= v_sync_s;
      blank       <= h_active_s & v_active_s;
      line_start  <= (h_next_s == {COUNT_W{1'b0}});
      frame_start <= (h_next_s == {COUNT_W{1'b0}}) && (v_next_s == {COUNT_W{1'b0}});
    end
  end

  // Frame counter; the wrap out of reset only starts frame 0.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_cnt     <= 8'd0;
      first_frame_r <= 1'b1;
    end else if (v_wrap_s) begin
      if (first_frame_r) begin
        first_frame_r <= 1'b0;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end else begin
      frame_cnt     <= frame_cnt;
      first_frame_r <= first_frame_r;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a tiny-raster
// instance checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int D_HV = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
  localparam int D_VV = 480, D_VFP = 10, D_VS = 2,  D_VBP = 33;
  localparam int D_HT = 800;
  localparam int S_HV = 8, S_HFP = 2, S_HS = 3, S_HBP = 1;
  localparam int S_VV = 4, S_VFP = 1, S_VS = 1, S_VBP = 1;
  localparam int S_FRAME = 98;

  logic       clk;
  logic       rst_d, rst_s;
  logic       hs_d, vs_d, blank_d, ls_d, fs_d;
  logic       hs_s, vs_s, blank_s, ls_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic [7:0] fc_d, fc_s;

  int t_d, t_s;
  int n_cmp, n_fail;
  bit collect_d, collect_s;
  int hs_low, hs_first, hs_last, ls_cnt, ls_prev, ls_period, blank_fall_x;
  int vs_cnt, blk_cnt, s_hs_cnt, fs_prev, fs_period, fc_at1, fc_at256;
  int target;

  vga_timing_gen dut_d (
    .vga_clk(clk), .reset(rst_d), .hs(hs_d), .vs(vs_d), .blank(blank_d),
    .DrawX(x_d), .DrawY(y_d), .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_ACTIVE(1'b1)
  ) dut_s (
    .vga_clk(clk), .reset(rst_s), .hs(hs_s), .vs(vs_s), .blank(blank_s),
    .DrawX(x_s), .DrawY(y_s), .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster position is pure arithmetic on cycles since reset release (t<0 = in reset).
  function automatic logic [32:0] model(input int t, input int hv, input int hfp, input int hsw,
                                        input int hbp, input int vv, input int vfp, input int vsw,
                                        input int vbp, input logic sa);
    int ht, vt, x, y, f;
    logic h_in, v_in;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    if (t < 0) begin
      x = ht - 1; y = vt - 1; f = 0;
    end else begin
      x = t % ht; y = (t / ht) % vt; f = (t / (ht * vt)) % 256;
    end
    h_in = (x >= hv + hfp) && (x < hv + hfp + hsw);
    v_in = (y >= vv + vfp) && (y < vv + vfp + vsw);
    return {(h_in ? sa : ~sa), (v_in ? sa : ~sa), ((x < hv) && (y < vv)), (x == 0),
            ((x == 0) && (y == 0)), 8'(f), 10'(x), 10'(y)};
  endfunction

  task automatic check_vec(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t_d=%0d t_s=%0d observed=%h expected=%h", tag, t_d, t_s, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check_vec({tag, "_d"}, {hs_d, vs_d, blank_d, ls_d, fs_d, fc_d, x_d, y_d},
              model(t_d, D_HV, D_HFP, D_HS, D_HBP, D_VV, D_VFP, D_VS, D_VBP, 1'b0));
    check_vec({tag, "_s"}, {hs_s, vs_s, blank_s, ls_s, fs_s, fc_s, x_s, y_s},
              model(t_s, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, 1'b1));
  endtask

  task automatic edge_update();
    @(posedge clk);
    t_d = rst_d ? -1 : t_d + 1;
    t_s = rst_s ? -1 : t_s + 1;
  endtask

  task automatic tick();
    edge_update();
    @(negedge clk);
    check_both("cycle");
    if (collect_d) begin
      if (t_d >= 800 && t_d < 1600 && !hs_d) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x_d);
        hs_last = int'(x_d);
      end
      if (ls_d && t_d < 2400) begin
        ls_cnt++;
        if (ls_prev >= 0) ls_period = t_d - ls_prev;
        ls_prev = t_d;
      end
      if (t_d >= 0 && t_d < 800 && !blank_d && blank_fall_x < 0) blank_fall_x = int'(x_d);
    end
    if (collect_s) begin
      if (t_s >= S_FRAME && t_s < 2 * S_FRAME) begin
        if (vs_s) vs_cnt++;
        if (blank_s) blk_cnt++;
      end
      if (t_s >= 0 && t_s < 14 && hs_s) s_hs_cnt++;
      if (fs_s) begin
        if (fs_prev >= 0) fs_period = t_s - fs_prev;
        fs_prev = t_s;
      end
      if (t_s == S_FRAME) fc_at1 = int'(fc_s);
      if (t_s == 256 * S_FRAME) fc_at256 = int'(fc_s);
    end
  endtask

  // Reset asserted between edges; outputs must react before the next edge.
  task automatic async_reset(input bit sel_s, input int hold, input int dly);
    edge_update();
    #(dly);
    if (sel_s) begin
      rst_s = 1'b1; t_s = -1;
    end else begin
      rst_d = 1'b1; t_d = -1;
    end
    #1;
    check_both("async_assert");
    @(negedge clk);
    check_both("async_hold");
    repeat (hold) tick();
  endtask

  initial begin
    rst_d = 1'b1; rst_s = 1'b1;
    t_d = -1; t_s = -1;
    n_cmp = 0; n_fail = 0;
    hs_low = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; ls_prev = -1; ls_period = -1;
    blank_fall_x = -1; vs_cnt = 0; blk_cnt = 0; s_hs_cnt = 0; fs_prev = -1; fs_period = -1;
    fc_at1 = -1; fc_at256 = -1;
    collect_d = 1'b1; collect_s = 1'b1;

    repeat (3) tick();
    rst_d = 1'b0;
    repeat ($urandom_range(1, 6)) tick();
    rst_s = 1'b0;
    repeat (2400) tick();
    collect_d = 1'b0;

    while (t_d % D_HT != 299) tick();
    async_reset(1'b0, 3, $urandom_range(1, 3));
    rst_d = 1'b0;
    tick();
    check_int("restart_x", int'(x_d), 0);
    check_int("restart_fc", int'(fc_d), 0);

    while (t_s < 256 * S_FRAME + 30) tick();
    collect_s = 1'b0;

    target = $urandom_range(1, S_FRAME - 1);
    while (t_s % S_FRAME != target) tick();
    async_reset(1'b1, $urandom_range(1, 4), $urandom_range(1, 3));
    rst_s = 1'b0;
    repeat (2 * S_FRAME) tick();

    check_int("hs_low_cycles", hs_low, 96);
    check_int("hs_first_x", hs_first, 656);
    check_int("hs_last_x", hs_last, 751);
    check_int("line_start_count", ls_cnt, 3);
    check_int("line_start_period", ls_period, 800);
    check_int("blank_fall_x", blank_fall_x, 640);
    check_int("small_vs_cycles", vs_cnt, 14);
    check_int("small_blank_cycles", blk_cnt, 32);
    check_int("small_hs_cycles", s_hs_cnt, 3);
    check_int("small_frame_period", fs_period, S_FRAME);
    check_int("small_fc_frame1", fc_at1, 1);
    check_int("small_fc_wrap256", fc_at256, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
